// File: rtl/fp_result_bcd_if.sv
// Handshake bundle for fp_result_bcd: float operand in, packed BCD result out.
// The master modport is the producer/consumer side; the slave modport is the converter.
interface fp_result_bcd_if;
   logic [31:0] input_z;
   logic        input_z_stb;
   logic        input_z_ack;
   logic [31:0] output_bcd;
   logic        output_sign;
   logic [2:0]  output_flags;
   logic        output_bcd_stb;
   logic        output_bcd_ack;

   modport master (
      output input_z, input_z_stb, output_bcd_ack,
      input  input_z_ack, output_bcd, output_sign, output_flags, output_bcd_stb
   );

   modport slave (
      input  input_z, input_z_stb, output_bcd_ack,
      output input_z_ack, output_bcd, output_sign, output_flags, output_bcd_stb
   );
endinterface

// File: rtl/fp_result_bcd.sv
// Converts an IEEE-754 single to the integer part (toward zero) as 8-digit packed BCD plus sign,
// with nan/inf/overflow flags. Multi-cycle: unpack, align, 27-step double-dabble, then hold.
module fp_result_bcd (
   input logic          clk,
   input logic          rst,
   fp_result_bcd_if.slave bus
);
   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StUnpack  = 3'd1;
   localparam logic [2:0] StAlign   = 3'd2;
   localparam logic [2:0] StConvert = 3'd3;
   localparam logic [2:0] StPut     = 3'd4;

   localparam logic [26:0] MaxValue = 27'd99999999;

   logic [2:0]  state_q, state_d;
   logic        ack_q, ack_d;
   logic        stb_q, stb_d;
   logic [31:0] z_q, z_d;
   logic [26:0] int_q, int_d;
   logic [31:0] bcd_q, bcd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] out_bcd_q, out_bcd_d;
   logic        out_sign_q, out_sign_d;
   logic [2:0]  out_flags_q, out_flags_d;

   logic [7:0]  exp_w;
   logic [22:0] mant_w;
   logic [26:0] aligned_w;
   logic [31:0] adj_w;
   logic [31:0] bcd_next_w;

   assign exp_w  = z_q[30:23];
   assign mant_w = z_q[22:0];

   // Biased exponent 150 means unbiased 23: the hidden-one significand is already an integer.
   assign aligned_w = (exp_w <= 8'd150) ? (27'({1'b1, mant_w}) >> (8'd150 - exp_w))
                                        : (27'({1'b1, mant_w}) << (exp_w - 8'd150));

   always_comb begin
      adj_w = bcd_q;
      for (int i = 0; i < 8; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj_w[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_next_w = {adj_w[30:0], int_q[26]};
   end

   always_comb begin
      state_d     = state_q;
      ack_d       = ack_q;
      stb_d       = stb_q;
      z_d         = z_q;
      int_d       = int_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      out_bcd_d   = out_bcd_q;
      out_sign_d  = out_sign_q;
      out_flags_d = out_flags_q;

      case (state_q)
         StIdle: begin
            if (!ack_q) begin
               ack_d = 1'b1;
            end else if (bus.input_z_stb) begin
               z_d     = bus.input_z;
               ack_d   = 1'b0;
               state_d = StUnpack;
            end
         end
         StUnpack: begin
            state_d = StPut;
            stb_d   = 1'b1;
            out_bcd_d = 32'h0;
            if (exp_w == 8'd255 && mant_w != 23'd0) begin
               out_flags_d = 3'b100;
               out_sign_d  = 1'b0;
            end else if (exp_w == 8'd255) begin
               out_flags_d = 3'b010;
               out_sign_d  = z_q[31];
            end else if (exp_w < 8'd127) begin
               // Zero, denormals and |x| < 1 all truncate to an unsigned zero.
               out_flags_d = 3'b000;
               out_sign_d  = 1'b0;
            end else if (exp_w >= 8'd154) begin
               out_flags_d = 3'b001;
               out_sign_d  = z_q[31];
            end else begin
               stb_d   = 1'b0;
               state_d = StAlign;
            end
         end
         StAlign: begin
            int_d = aligned_w;
            bcd_d = 32'h0;
            cnt_d = 5'd0;
            if (aligned_w > MaxValue) begin
               out_bcd_d   = 32'h0;
               out_flags_d = 3'b001;
               out_sign_d  = z_q[31];
               stb_d       = 1'b1;
               state_d     = StPut;
            end else begin
               state_d = StConvert;
            end
         end
         StConvert: begin
            bcd_d = bcd_next_w;
            int_d = {int_q[25:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd26) begin
               // Integer is >= 1 here, so the sign always follows the operand.
               out_bcd_d   = bcd_next_w;
               out_flags_d = 3'b000;
               out_sign_d  = z_q[31];
               stb_d       = 1'b1;
               state_d     = StPut;
            end
         end
         StPut: begin
            if (bus.output_bcd_ack) begin
               stb_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ack_q       <= 1'b0;
         stb_q       <= 1'b0;
         z_q         <= 32'h0;
         int_q       <= 27'h0;
         bcd_q       <= 32'h0;
         cnt_q       <= 5'd0;
         out_bcd_q   <= 32'h0;
         out_sign_q  <= 1'b0;
         out_flags_q <= 3'b000;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         stb_q       <= stb_d;
         z_q         <= z_d;
         int_q       <= int_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         out_bcd_q   <= out_bcd_d;
         out_sign_q  <= out_sign_d;
         out_flags_q <= out_flags_d;
      end
   end

   assign bus.input_z_ack    = ack_q;
   assign bus.output_bcd_stb = stb_q;
   assign bus.output_bcd     = out_bcd_q;
   assign bus.output_sign    = out_sign_q;
   assign bus.output_flags   = out_flags_q;
endmodule

// File: tb/tb_fp_result_bcd.sv
// Bench for fp_result_bcd: directed and random floats against a real-arithmetic reference,
// plus back-pressure and mid-conversion reset scenarios.
module tb_fp_result_bcd;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fp_result_bcd_if bus ();

   fp_result_bcd dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference: decode the float as a real number, truncate, and print decimal digits.
   task automatic model(input logic [31:0] z, output logic [31:0] bcd, output logic sgn,
                        output logic [2:0] flg, output int lat);
      int  ex;
      real v;
      int  iv;
      bcd = 32'h0;
      sgn = z[31];
      flg = 3'b000;
      lat = 2;
      ex  = int'(z[30:23]);
      if (ex == 255) begin
         if (z[22:0] != 23'd0) begin
            flg = 3'b100;
            sgn = 1'b0;
         end else begin
            flg = 3'b010;
         end
      end else if (ex == 0 || ex - 127 < 0) begin
         sgn = 1'b0;
      end else if (ex - 127 >= 27) begin
         flg = 3'b001;
      end else begin
         v = (8388608.0 + real'(z[22:0])) / 8388608.0;
         for (int k = 0; k < ex - 127; k++) v = v * 2.0;
         iv = $rtoi(v);
         if (iv > 99999999) begin
            flg = 3'b001;
            lat = 3;
         end else begin
            lat = 30;
            for (int d = 0; d < 8; d++) begin
               bcd[4*d +: 4] = 4'(iv % 10);
               iv = iv / 10;
            end
         end
      end
   endtask

   // Hands one operand over; returns with cyc = first cycle (transfer edge = cycle 0) seen with
   // output_bcd_stb high, or ok = 0 if either handshake never happened.
   task automatic do_transfer(input logic [31:0] z, output int cyc, output bit ok);
      int w = 0;
      ok = 1'b1;
      while (!bus.input_z_ack && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (!bus.input_z_ack) begin
         ok = 1'b0;
         cyc = 0;
         return;
      end
      bus.input_z     = z;
      bus.input_z_stb = 1'b1;
      @(posedge clk);
      #1;
      bus.input_z_stb = 1'b0;
      cyc = 1;
      while (!bus.output_bcd_stb && cyc < 45) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!bus.output_bcd_stb) ok = 1'b0;
   endtask

   task automatic release_output();
      bus.output_bcd_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.output_bcd_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.input_z = 32'h0;
      bus.input_z_stb = 1'b0;
      bus.output_bcd_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.input_z_ack !== 1'b0 || bus.output_bcd_stb !== 1'b0 || bus.output_bcd !== 32'h0 ||
          bus.output_sign !== 1'b0 || bus.output_flags !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: ack=%b stb=%b bcd=%h sign=%b flags=%b, required all zero",
                  bus.input_z_ack, bus.output_bcd_stb, bus.output_bcd, bus.output_sign,
                  bus.output_flags);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.input_z_ack !== 1'b1 || bus.output_bcd_stb !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ack=%b stb=%b, required ack=1 stb=0",
                  bus.input_z_ack, bus.output_bcd_stb);
      end
   endtask

   task automatic test_vectors(input logic [31:0] vec[$], input string tag);
      logic [31:0] eb;
      logic        es;
      logic [2:0]  ef;
      int          el;
      int          cyc;
      bit          ok;
      foreach (vec[i]) begin
         model(vec[i], eb, es, ef, el);
         do_transfer(vec[i], cyc, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s_handshake z=%h: no strobe within bound, required strobe", tag,
                     vec[i]);
            release_output();
            continue;
         end
         checks++;
         if (cyc !== el) begin
            errors++;
            $display("FAIL %s_latency z=%h: got cycle %0d, required %0d", tag, vec[i], cyc, el);
         end
         checks++;
         if (bus.output_bcd !== eb || bus.output_sign !== es || bus.output_flags !== ef) begin
            errors++;
            $display("FAIL %s_result z=%h: got bcd=%h sign=%b flags=%b, required bcd=%h sign=%b flags=%b",
                     tag, vec[i], bus.output_bcd, bus.output_sign, bus.output_flags, eb, es, ef);
         end
         release_output();
         checks++;
         if (bus.output_bcd_stb !== 1'b0 || bus.output_bcd !== eb) begin
            errors++;
            $display("FAIL %s_after_ack z=%h: got stb=%b bcd=%h, required stb=0 bcd=%h", tag,
                     vec[i], bus.output_bcd_stb, bus.output_bcd, eb);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] vec[$];
      vec = '{32'h3F800000, 32'h4B800000, 32'hC2F78000, 32'h4CBEBC20, 32'h7F000000,
              32'h7FC00000, 32'hFF800000, 32'hBF000000, 32'h00000001, 32'h42C80000,
              32'h80000000, 32'h4CBEBC1F, 32'hCB7FFFFF};
      test_vectors(vec, "directed");
   endtask

   task automatic test_random();
      logic [31:0] vec[$];
      logic [7:0]  ex;
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 7) ex = 8'($urandom_range(0, 255));
         else ex = 8'($urandom_range(124, 156));
         vec.push_back({1'($urandom_range(0, 1)), ex, 23'($urandom)});
      end
      test_vectors(vec, "random");
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit ok;
      do_transfer(32'h3F800000, cyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL backpressure_handshake: no strobe within bound, required strobe");
      end
      for (int i = 0; i < 10; i++) begin
         bus.input_z     = $urandom;
         bus.input_z_stb = 1'(i % 2);
         @(posedge clk);
         #1;
         checks++;
         if (bus.output_bcd_stb !== 1'b1 || bus.output_bcd !== 32'h1 ||
             bus.output_flags !== 3'b000 || bus.output_sign !== 1'b0 ||
             bus.input_z_ack !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold cycle %0d: stb=%b bcd=%h flags=%b sign=%b ack=%b, required 1 00000001 000 0 0",
                     i, bus.output_bcd_stb, bus.output_bcd, bus.output_flags, bus.output_sign,
                     bus.input_z_ack);
         end
      end
      bus.input_z_stb = 1'b0;
      release_output();
      checks++;
      if (bus.output_bcd_stb !== 1'b0 || bus.input_z_ack !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release: stb=%b ack=%b, required stb=0 ack=0",
                  bus.output_bcd_stb, bus.input_z_ack);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.input_z_ack !== 1'b1 || bus.output_bcd !== 32'h1) begin
         errors++;
         $display("FAIL backpressure_ack_return: ack=%b bcd=%h, required ack=1 bcd=00000001",
                  bus.input_z_ack, bus.output_bcd);
      end
   endtask

   task automatic test_mid_reset();
      int cyc;
      bit ok;
      int w = 0;
      while (!bus.input_z_ack && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      bus.input_z     = 32'h3F800000;
      bus.input_z_stb = 1'b1;
      @(posedge clk);
      #1;
      bus.input_z_stb = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.input_z_ack !== 1'b0 || bus.output_bcd_stb !== 1'b0 || bus.output_bcd !== 32'h0 ||
          bus.output_sign !== 1'b0 || bus.output_flags !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_outputs: ack=%b stb=%b bcd=%h sign=%b flags=%b, required all zero",
                  bus.input_z_ack, bus.output_bcd_stb, bus.output_bcd, bus.output_sign,
                  bus.output_flags);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_transfer(32'h42C80000, cyc, ok);
      checks++;
      if (!ok || cyc !== 30 || bus.output_bcd !== 32'h00000100 || bus.output_sign !== 1'b0 ||
          bus.output_flags !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_followup: ok=%b cycle=%0d bcd=%h sign=%b flags=%b, required 1 30 00000100 0 000",
                  ok, cyc, bus.output_bcd, bus.output_sign, bus.output_flags);
      end
      release_output();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
